// File: rtl/vdc_pkg.sv
// -----------------------------------------------------------------------------
// vdc_pkg
// Shared definitions for the variable-duty-cycle heater PWM stage.
//   - DEF_PERIOD / DEF_CNT_W / DEF_MIN_PULSE : default parameter values
//   - vdc_state_e                            : IDLE / RUN state encoding
//   - vdc_clamp()                            : NH -> duty clamp, with optional
//                                              minimum-pulse deadband
// Build option: define VDC_MIN_PULSE_EN to enable the minimum-pulse deadband.
// -----------------------------------------------------------------------------
package vdc_pkg;

  localparam int DEF_PERIOD    = 100000;
  localparam int DEF_CNT_W     = 17;
  localparam int DEF_MIN_PULSE = 100;

`ifdef VDC_MIN_PULSE_EN
  localparam bit MIN_PULSE_EN = 1'b1;
`else
  localparam bit MIN_PULSE_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vdc_state_e;

  // Clamp a signed NH request into 0..period. With the deadband enabled,
  // durations shorter than min_pulse on either side of the pulse are removed
  // by snapping the duty to the nearest endpoint.
  function automatic longint vdc_clamp(input longint nh,
                                       input longint period,
                                       input longint min_pulse);
    longint d;
    if (nh < 0)
      d = 0;
    else if (nh > period)
      d = period;
    else
      d = nh;
    if (MIN_PULSE_EN) begin
      if (d > 0 && d < min_pulse)
        d = 0;
      else if (d > period - min_pulse && d < period)
        d = period;
    end
    return d;
  endfunction

endpackage

// File: rtl/vdc_period_counter.sv
// -----------------------------------------------------------------------------
// vdc_period_counter
// Period counter for the VDC stage: counts 0..PERIOD-1 while enabled and wraps.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : advance the counter this cycle
//   clr  : synchronous clear to 0 (overrides en)
//   cnt  : current count
//   wrap : high in the enabled cycle where cnt == PERIOD-1 (period boundary)
// -----------------------------------------------------------------------------
module vdc_period_counter
  import vdc_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign wrap = en && (cnt_reg == LAST);
  assign cnt  = cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt_reg <= '0;
    else if (en)
      cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
  end

endmodule

// File: rtl/vdc_pwm_gen.sv
// -----------------------------------------------------------------------------
// vdc_pwm_gen
// Variable-duty-cycle PWM output stage for the temperature servos. Takes the
// PID's NH word (high cycles per period), double-buffers it and drives a
// glitch-free PWM with one duty update per period.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   on           : enable; low forces idle (output low, counter cleared)
//   nh_valid     : strobe qualifying nh_in
//   nh_in        : signed requested high count
//   vdc_out      : registered PWM drive
//   period_start : one-cycle pulse in the first cycle (cnt == 0) of a period
//   duty_active  : duty in force for the current period
// Build option: VDC_MIN_PULSE_EN enables the minimum-pulse deadband in
// vdc_clamp (see vdc_pkg); otherwise MIN_PULSE has no effect.
// -----------------------------------------------------------------------------
module vdc_pwm_gen
  import vdc_pkg::*;
#(
  parameter int FILTER_IO_SIZE = 18,
  parameter int PERIOD         = DEF_PERIOD,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int MIN_PULSE      = DEF_MIN_PULSE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             on,
  input  logic                             nh_valid,
  input  logic signed [FILTER_IO_SIZE-1:0] nh_in,
  output logic                             vdc_out,
  output logic                             period_start,
  output logic        [CNT_W-1:0]          duty_active
);

  vdc_state_e       state_reg;
  logic [CNT_W-1:0] pending_reg;
  logic [CNT_W-1:0] duty_active_reg;
  logic             vdc_out_reg;
  logic             period_start_reg;

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] nh_clamped;
  logic [CNT_W-1:0] duty_next;
  logic             cnt_en;
  logic             cnt_clr;

  assign nh_clamped = CNT_W'(vdc_clamp(longint'(nh_in), longint'(PERIOD),
                                       longint'(MIN_PULSE)));

  // A write on the boundary cycle bypasses pending straight into the new duty.
  assign duty_next = nh_valid ? nh_clamped : pending_reg;

  // The counter holds the count of the cycle currently on the output, so
  // it stays cleared through the IDLE->RUN cycle and starts advancing after.
  assign cnt_en  = (state_reg == RUN) && on;
  assign cnt_clr = (state_reg == IDLE) || !on;
  assign cnt_inc = cnt + 1'b1;

  vdc_period_counter #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Outputs are computed from the next cycle's count and duty so the
  // registered vdc_out lines up with period_start and duty_active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      duty_active_reg  <= '0;
      vdc_out_reg      <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      if (nh_valid)
        pending_reg <= nh_clamped;
      period_start_reg <= 1'b0;
      if (!on) begin
        state_reg   <= IDLE;
        vdc_out_reg <= 1'b0;
      end else if (state_reg == IDLE || wrap) begin
        // Period boundary: next output cycle has cnt == 0.
        state_reg        <= RUN;
        duty_active_reg  <= duty_next;
        period_start_reg <= 1'b1;
        vdc_out_reg      <= (duty_next != '0);
      end else begin
        vdc_out_reg <= (cnt_inc < duty_active_reg);
      end
    end
  end

  assign vdc_out      = vdc_out_reg;
  assign period_start = period_start_reg;
  assign duty_active  = duty_active_reg;

endmodule

// File: tb/tb_vdc_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_vdc_pwm_gen
// Directed bench for vdc_pwm_gen with a shortened period (PERIOD = 100).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vdc_pwm_gen;

  localparam int FW    = 18;
  localparam int P     = 100;
  localparam int CW    = 7;
  localparam int MINP  = 10;
  localparam int LIMIT = 2 * P + 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 on;
  logic                 nh_valid;
  logic signed [FW-1:0] nh_in;
  logic                 vdc_out;
  logic                 period_start;
  logic [CW-1:0]        duty_active;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vdc_pwm_gen #(
    .FILTER_IO_SIZE (FW),
    .PERIOD         (P),
    .CNT_W          (CW),
    .MIN_PULSE      (MINP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .on           (on),
    .nh_valid     (nh_valid),
    .nh_in        (nh_in),
    .vdc_out      (vdc_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic write_nh(input int v);
    nh_in    = v[FW-1:0];
    nh_valid = 1'b1;
    @(negedge clk);
    nh_valid = 1'b0;
  endtask

  // Advance to the falling edge of the next period's first cycle.
  task automatic wait_ps(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_ps_timeout"}, 0, 1);
  endtask

  // Called at the falling edge of a period's first cycle. Counts high samples,
  // the leading high run and the period length; returns at the falling edge
  // of the following period's first cycle. Optionally writes wr_val in the
  // cycle whose count equals wr_at.
  task automatic measure(input string tag, input int wr_at, input int wr_val,
                         output int high, output int run, output int len);
    bit run_open;
    bit ended;
    high     = vdc_out ? 1 : 0;
    run      = high;
    run_open = vdc_out;
    len      = 1;
    ended    = 1'b0;
    if (wr_at == 0) begin
      nh_in = wr_val[FW-1:0];
      nh_valid = 1'b1;
    end
    for (int i = 1; i < LIMIT; i++) begin
      @(negedge clk);
      nh_valid = 1'b0;
      if (period_start) begin
        ended = 1'b1;
        break;
      end
      if (vdc_out) high++;
      if (vdc_out && run_open) run++;
      else run_open = 1'b0;
      len++;
      if (i == wr_at) begin
        nh_in = wr_val[FW-1:0];
        nh_valid = 1'b1;
      end
    end
    if (!ended) check({tag, "_len_timeout"}, 0, 1);
    $display("period %s: high=%0d run=%0d len=%0d duty_active=%0d",
             tag, high, run, len, duty_active);
  endtask

  int h, r, l;
  int exp_lo, exp_hi;

  initial begin
    rst = 1'b1; on = 1'b0; nh_valid = 1'b0; nh_in = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_vdc_out", vdc_out, 0);
    check("rst_ps", period_start, 0);
    check("rst_duty", duty_active, 0);

    // Nominal: duty 25 loaded while idle, then enable.
    write_nh(25);
    check("idle_out_low", vdc_out, 0);
    on = 1'b1;
    tick(1);
    check("on_ps", period_start, 1);
    check("on_first_high", vdc_out, 1);
    check("on_duty", duty_active, 25);
    measure("nom1", -1, 0, h, r, l);
    check("nom1_high", h, 25); check("nom1_run", r, 25); check("nom1_len", l, P);
    measure("nom2", -1, 0, h, r, l);
    check("nom2_high", h, 25); check("nom2_len", l, P);

    // Clamp negative -> all low; current period keeps its duty.
    measure("neg_write", 1, -5, h, r, l);
    check("neg_cur_high", h, 25);
    check("neg_duty", duty_active, 0);
    measure("neg", -1, 0, h, r, l);
    check("neg_high", h, 0);

    // Clamp large -> continuous high across boundaries.
    measure("big_write", 1, 131071, h, r, l);
    check("big_duty", duty_active, P);
    measure("big1", -1, 0, h, r, l);
    check("big1_run", r, P);
    measure("big2", -1, 0, h, r, l);
    check("big2_run", r, P); check("big2_len", l, P);

    // Double buffering: mid-period write affects next period only.
    measure("db_pre", 1, 20, h, r, l);
    measure("db_mid", 10, 40, h, r, l);
    check("db_mid_high", h, 20); check("db_mid_run", r, 20);
    measure("db_next", P - 1, 60, h, r, l);
    check("db_next_high", h, 40);
    check("bnd_duty", duty_active, 60);
    measure("bnd", -1, 0, h, r, l);
    check("bnd_high", h, 60);

    // On/off: drop on at cnt 3 of a duty-10 period.
    measure("onoff_pre", 1, 10, h, r, l);
    check("onoff_duty", duty_active, 10);
    tick(3);
    check("onoff_high_cnt3", vdc_out, 1);
    on = 1'b0;
    tick(1);
    check("off_low", vdc_out, 0);
    check("off_duty_held", duty_active, 10);
    tick(5);
    check("off_no_ps", period_start, 0);
    on = 1'b1;
    tick(1);
    check("reon_ps", period_start, 1);
    measure("reon", -1, 0, h, r, l);
    check("reon_high", h, 10); check("reon_run", r, 10); check("reon_len", l, P);

    // Minimum-pulse deadband (build dependent).
`ifdef VDC_MIN_PULSE_EN
    exp_lo = 0;  exp_hi = P;
`else
    exp_lo = 5;  exp_hi = P - 5;
`endif
    measure("mp_lo_write", 1, 5, h, r, l);
    measure("mp_lo", -1, 0, h, r, l);
    check("mp_lo_high", h, exp_lo);
    measure("mp_hi_write", 1, P - 5, h, r, l);
    measure("mp_hi", -1, 0, h, r, l);
    check("mp_hi_high", h, exp_hi);

    // Reset mid-period with a pending write outstanding.
    measure("rst_pre", 1, 50, h, r, l);
    tick(20);
    check("rst_pre_high", vdc_out, 1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_out", vdc_out, 0);
    check("rst_mid_duty", duty_active, 0);
    check("rst_mid_ps", period_start, 0);
    rst = 1'b0;
    tick(1);
    check("rst_restart_ps", period_start, 1);
    measure("post_rst", -1, 0, h, r, l);
    check("post_rst_high", h, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
